// File: rtl/camera_pack.sv
// camera_pack
//   Capture-side packer in the camera pixel clock domain. Samples the 8-bit
//   camera bus framed by vsync/href and packs 16 bytes (8 RGB565 pixels) into
//   one 128-bit word. Each word is tagged with its SDRAM word address, the HDR
//   exposure buffer index (rotating 0->1->2->0) and a last-word flag.
//
//   Ports
//     p_clk        in   1    camera pixel clock (only clock)
//     rst          in   1    asynchronous, active-high reset
//     cam_data     in   8    camera data byte
//     vsync        in   1    frame sync, high during vertical blank
//     href         in   1    line valid, high while cam_data is active
//     capture_en   in   1    capture enable, sampled when vertical blank ends
//     p_data       out  128  packed word, byte 0 (first received) in [7:0]
//     wr_address   out  25   SDRAM word address of p_data
//     change_frame out  2    buffer index (0..2) of the emitted word
//     frame_done   out  1    high with the last word of a frame
//     data_valid   out  1    single-cycle strobe qualifying the outputs above
//     frame_err    out  1    sticky short/long frame flag, cleared by rst
//
//   Build option
//     CAMERA_PACK_TEST_PATTERN_EN : replace cam_data with an 8-bit byte
//     counter that restarts at 0 at the end of every vertical blank.

module camera_pack #(
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned FRAME_WORDS  = H_ACTIVE * V_ACTIVE * 2 / 16,
   parameter logic [24:0] FRAME_STRIDE = 25'h0010000,
   parameter logic [24:0] BASE_ADDR    = 25'h0000000
) (
   input  logic         p_clk,
   input  logic         rst,
   input  logic [7:0]   cam_data,
   input  logic         vsync,
   input  logic         href,
   input  logic         capture_en,
   output logic [127:0] p_data,
   output logic [24:0]  wr_address,
   output logic [1:0]   change_frame,
   output logic         frame_done,
   output logic         data_valid,
   output logic         frame_err
);

   localparam logic [16:0] FULL_WORDS = 17'(FRAME_WORDS);
   localparam logic [16:0] LAST_WORD  = 17'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {
      S_SYNC,
      S_VBLANK,
      S_SKIP,
      S_ACTIVE
   } state_t;

   state_t       state_q;
   logic [3:0]   byte_cnt_q;
   logic [16:0]  word_cnt_q;
   logic [16:0]  word_cnt_d;
   logic [127:0] word_q;          // assembly buffer for the word in progress
   logic [127:0] word_d;          // buffer with the current byte merged in
   logic [1:0]   buf_idx_q;       // buffer the frame being captured writes to
   logic [127:0] p_data_q;
   logic [24:0]  wr_address_q;
   logic [1:0]   change_frame_q;
   logic         frame_done_q;
   logic         data_valid_q;
   logic         frame_err_q;

   logic [7:0]   byte_in;
   logic         byte_take;
   logic         word_full;
   logic         word_emit;
   logic [24:0]  frame_base;

`ifdef CAMERA_PACK_TEST_PATTERN_EN
   logic [7:0] pat_cnt_q;
   logic       unused_cam_data;

   assign unused_cam_data = ^cam_data;
   assign byte_in         = pat_cnt_q;

   // Counts accepted bytes only, so word j always holds bytes 16j..16j+15.
   always_ff @(posedge p_clk or posedge rst) begin
      if (rst) begin
         pat_cnt_q <= '0;
      end else if (state_q == S_VBLANK && !vsync) begin
         pat_cnt_q <= '0;
      end else if (byte_take) begin
         pat_cnt_q <= pat_cnt_q + 8'd1;
      end
   end
`else
   assign byte_in = cam_data;
`endif

   assign byte_take  = (state_q == S_ACTIVE) && href;
   assign word_full  = byte_take && (byte_cnt_q == 4'd15);
   assign word_emit  = word_full && (word_cnt_q < FULL_WORDS);
   // Word count including a word completing this cycle; the end-of-frame
   // check must see it when vsync rises together with the 16th byte.
   assign word_cnt_d = word_emit ? word_cnt_q + 17'd1 : word_cnt_q;
   assign frame_base = BASE_ADDR + FRAME_STRIDE * {23'd0, buf_idx_q};

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_slot
         assign word_d[8*gi +: 8] = (byte_cnt_q == 4'(gi)) ? byte_in : word_q[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge p_clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_SYNC;
         byte_cnt_q     <= '0;
         word_cnt_q     <= '0;
         word_q         <= '0;
         buf_idx_q      <= '0;
         p_data_q       <= '0;
         wr_address_q   <= '0;
         change_frame_q <= '0;
         frame_done_q   <= 1'b0;
         data_valid_q   <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            S_SYNC: begin
               // Never start mid-frame: wait for a vertical blank first.
               if (vsync) state_q <= S_VBLANK;
            end
            S_VBLANK: begin
               byte_cnt_q <= '0;
               word_cnt_q <= '0;
               if (!vsync) state_q <= capture_en ? S_ACTIVE : S_SKIP;
            end
            S_SKIP: begin
               if (vsync) state_q <= S_VBLANK;
            end
            S_ACTIVE: begin
               if (byte_take) begin
                  word_q     <= word_d;
                  byte_cnt_q <= byte_cnt_q + 4'd1;
               end
               if (word_emit) begin
                  data_valid_q   <= 1'b1;
                  p_data_q       <= word_d;
                  wr_address_q   <= frame_base + {8'd0, word_cnt_q};
                  change_frame_q <= buf_idx_q;
                  frame_done_q   <= (word_cnt_q == LAST_WORD);
                  // Rotate for the next frame; this word keeps the old index.
                  if (word_cnt_q == LAST_WORD) begin
                     buf_idx_q <= (buf_idx_q == 2'd2) ? 2'd0 : buf_idx_q + 2'd1;
                  end
               end else if (word_full) begin
                  frame_err_q <= 1'b1;    // word beyond the end of the frame
               end
               word_cnt_q <= word_cnt_d;
               if (vsync) begin
                  if (word_cnt_d != FULL_WORDS) frame_err_q <= 1'b1;
                  state_q <= S_VBLANK;
               end
            end
            default: state_q <= S_SYNC;
         endcase
      end
   end

   assign p_data       = p_data_q;
   assign wr_address   = wr_address_q;
   assign change_frame = change_frame_q;
   assign frame_done   = frame_done_q;
   assign data_valid   = data_valid_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_camera_pack.sv
// Testbench for camera_pack, using a reduced 32x4 frame (16 words per frame,
// 4 words per line) so that many frames fit in a short run. A table of frame
// scenarios carries the expected strobe count, first address/index and error
// flag; word contents come from a reference model that slices the recorded
// byte stream of each frame into groups of 16.

module tb_camera_pack;

   localparam int          H          = 32;
   localparam int          V          = 4;
   localparam int          FW         = H * V * 2 / 16;
   localparam int          LINE_BYTES = H * 2;
   localparam logic [24:0] STRIDE     = 25'h0010000;
   localparam logic [24:0] BASE       = 25'h0000000;

   logic         p_clk = 1'b0;
   logic         rst;
   logic [7:0]   cam_data;
   logic         vsync;
   logic         href;
   logic         capture_en;
   logic [127:0] p_data;
   logic [24:0]  wr_address;
   logic [1:0]   change_frame;
   logic         frame_done;
   logic         data_valid;
   logic         frame_err;

   always #5 p_clk = ~p_clk;

   camera_pack #(
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .FRAME_WORDS (FW),
      .FRAME_STRIDE(STRIDE),
      .BASE_ADDR   (BASE)
   ) dut (
      .p_clk       (p_clk),
      .rst         (rst),
      .cam_data    (cam_data),
      .vsync       (vsync),
      .href        (href),
      .capture_en  (capture_en),
      .p_data      (p_data),
      .wr_address  (wr_address),
      .change_frame(change_frame),
      .frame_done  (frame_done),
      .data_valid  (data_valid),
      .frame_err   (frame_err)
   );

   typedef struct {
      logic [127:0] d;
      logic [24:0]  a;
      logic [1:0]   cf;
      logic         fd;
   } obs_t;

   typedef struct {
      int          cap;
      int          lines;
      int          extra;
      int          vs_last;
      int          idx_data;
      int          exp_strobes;
      int          exp_cf;
      logic [24:0] exp_first;
      int          exp_err;
   } frame_vec_t;

   obs_t         obs_q[$];
   logic [7:0]   bytes_q[$];
   frame_vec_t   tbl[10];

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           last_strobe = -100;

   // reference model state
   int           m_idx;
   int           m_err;
   logic [127:0] m_last_d;
   logic [24:0]  m_last_a;
   logic [1:0]   m_last_cf;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge p_clk);
      #1;
   endtask

   // Strobe collector plus the cycle-level protocol rules.
   always @(negedge p_clk) begin
      cyc++;
      if (data_valid === 1'b1) begin
         obs_q.push_back('{p_data, wr_address, change_frame, frame_done});
         checks++;
         if (cyc - last_strobe < 16) begin
            failures++;
            $display("FAIL strobe_spacing actual=%0d required>=16", cyc - last_strobe);
         end
         last_strobe = cyc;
      end else begin
         checks++;
         if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_without_valid actual=%b required=0", frame_done);
         end
      end
   end

   // Starts and ends with vsync high. Records every byte the DUT would
   // sample while active into bytes_q.
   task automatic drive_frame(input int cap, input int lines, input int extra,
                              input int vs_last, input int idx_data);
      int         total;
      int         nlines;
      int         cnt;
      int         n;
      logic [7:0] d;
      total  = lines * LINE_BYTES + extra;
      nlines = lines + ((extra > 0) ? 1 : 0);
      n      = 0;
      capture_en = cap[0];
      vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      tick();
      capture_en = 1'($urandom);      // must be ignored from here on
      repeat (2) tick();
      for (int l = 0; l < nlines; l++) begin
         cnt = (l < lines) ? LINE_BYTES : extra;
         for (int b = 0; b < cnt; b++) begin
            d        = (idx_data != 0) ? 8'(n) : 8'($urandom);
            href     = 1'b1;
            cam_data = d;
`ifdef CAMERA_PACK_TEST_PATTERN_EN
            bytes_q.push_back(8'(n));
`else
            bytes_q.push_back(d);
`endif
            if (vs_last != 0 && n == total - 1) vsync = 1'b1;
            tick();
            n++;
         end
         href     = 1'b0;
         cam_data = 8'($urandom);
         repeat ($urandom_range(1, 4)) tick();
      end
      vsync = 1'b1;
      repeat (4) tick();
   endtask

   task automatic check_frame(input frame_vec_t v, input int fno);
      int           nw;
      int           emit;
      logic [127:0] ed;
      logic [24:0]  ea;
      nw   = bytes_q.size() / 16;
      emit = (v.cap != 0) ? ((nw < FW) ? nw : FW) : 0;
      chk($sformatf("strobe_count f%0d", fno), 128'(obs_q.size()), 128'(v.exp_strobes));
      for (int k = 0; k < obs_q.size() && k < emit; k++) begin
         for (int i = 0; i < 16; i++) ed[8*i +: 8] = bytes_q[16*k + i];
         ea = BASE + 25'(m_idx) * STRIDE + 25'(k);
         $display("word f=%0d k=%0d addr=%h cf=%0d fd=%0d data=%h",
                  fno, k, obs_q[k].a, obs_q[k].cf, obs_q[k].fd, obs_q[k].d);
         chk($sformatf("p_data f%0d k%0d", fno, k), obs_q[k].d, ed);
         chk($sformatf("wr_address f%0d k%0d", fno, k), 128'(obs_q[k].a), 128'(ea));
         chk($sformatf("change_frame f%0d k%0d", fno, k), 128'(obs_q[k].cf), 128'(m_idx));
         chk($sformatf("frame_done f%0d k%0d", fno, k), 128'(obs_q[k].fd), 128'((k == FW - 1) ? 1 : 0));
         m_last_d  = ed;
         m_last_a  = ea;
         m_last_cf = 2'(m_idx);
      end
      if (obs_q.size() > 0) begin
         chk($sformatf("first_addr f%0d", fno), 128'(obs_q[0].a), 128'(v.exp_first));
         chk($sformatf("first_cf f%0d", fno), 128'(obs_q[0].cf), 128'(v.exp_cf));
      end
      if (v.cap != 0) begin
         if (nw >= FW) m_idx = (m_idx + 1) % 3;
         if (nw != FW) m_err = 1;
      end
      chk($sformatf("frame_err f%0d", fno), 128'(frame_err), 128'(v.exp_err));
      chk($sformatf("frame_err_model f%0d", fno), 128'(frame_err), 128'(m_err));
      chk($sformatf("hold_p_data f%0d", fno), p_data, m_last_d);
      chk($sformatf("hold_wr_address f%0d", fno), 128'(wr_address), 128'(m_last_a));
      chk($sformatf("hold_change_frame f%0d", fno), 128'(change_frame), 128'(m_last_cf));
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, " p_data"}, p_data, 128'd0);
      chk({tag, " wr_address"}, 128'(wr_address), 128'd0);
      chk({tag, " change_frame"}, 128'(change_frame), 128'd0);
      chk({tag, " frame_done"}, 128'(frame_done), 128'd0);
      chk({tag, " data_valid"}, 128'(data_valid), 128'd0);
      chk({tag, " frame_err"}, 128'(frame_err), 128'd0);
   endtask

   initial begin
      logic [127:0] first_word;
      first_word = 128'h0F0E0D0C0B0A09080706050403020100;

      rst        = 1'b1;
      vsync      = 1'b1;
      href       = 1'b0;
      cam_data   = 8'd0;
      capture_en = 1'b0;
      m_idx      = 0;
      m_err      = 0;
      m_last_d   = '0;
      m_last_a   = '0;
      m_last_cf  = '0;
      repeat (3) tick();
      check_outputs_zero("reset");
      rst = 1'b0;
      tick();

      //         cap lines extra vs_last idx  strobes cf first       err
      tbl[0] = '{1,  4,    0,    0,      1,   16,     0,  25'h0000000, 0};
      tbl[1] = '{1,  4,    0,    0,      0,   16,     1,  25'h0010000, 0};
      tbl[2] = '{1,  4,    0,    0,      0,   16,     2,  25'h0020000, 0};
      tbl[3] = '{1,  4,    0,    0,      0,   16,     0,  25'h0000000, 0};
      tbl[4] = '{0,  4,    0,    0,      0,   0,      0,  25'h0000000, 0};
      tbl[5] = '{1,  4,    8,    0,      0,   16,     1,  25'h0010000, 0};
      tbl[6] = '{1,  4,    0,    1,      0,   16,     2,  25'h0020000, 0};
      tbl[7] = '{1,  4,    16,   0,      0,   16,     0,  25'h0000000, 1};
      tbl[8] = '{1,  3,    0,    0,      0,   12,     1,  25'h0010000, 1};
      tbl[9] = '{1,  4,    0,    0,      0,   16,     1,  25'h0010000, 1};

      for (int f = 0; f < 10; f++) begin
         obs_q.delete();
         bytes_q.delete();
         drive_frame(tbl[f].cap, tbl[f].lines, tbl[f].extra, tbl[f].vs_last, tbl[f].idx_data);
         check_frame(tbl[f], f);
         if (f == 0 && obs_q.size() == FW) begin
            chk("first_word_value", obs_q[0].d, first_word);
            chk("last_word_addr", 128'(obs_q[FW-1].a), 128'(FW - 1));
            chk("last_word_done", 128'(obs_q[FW-1].fd), 128'd1);
         end
      end

      // Reset in the middle of active data, released with vsync still low.
      obs_q.delete();
      bytes_q.delete();
      capture_en = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      repeat (3) tick();
      for (int b = 0; b < 2 * LINE_BYTES + 5; b++) begin
         href     = 1'b1;
         cam_data = 8'($urandom);
         tick();
      end
      rst = 1'b1;
      obs_q.delete();
      repeat (3) tick();
      check_outputs_zero("midframe_reset");
      rst = 1'b0;
      for (int b = 0; b < LINE_BYTES + 11; b++) begin
         cam_data = 8'($urandom);
         tick();
      end
      href = 1'b0;
      repeat (3) tick();
      for (int b = 0; b < LINE_BYTES; b++) begin
         href     = 1'b1;
         cam_data = 8'($urandom);
         tick();
      end
      href = 1'b0;
      repeat (2) tick();
      vsync = 1'b1;
      repeat (4) tick();
      chk("no_strobe_after_reset", 128'(obs_q.size()), 128'd0);
      $display("reset sequence strobes=%0d", obs_q.size());

      m_idx     = 0;
      m_err     = 0;
      m_last_d  = '0;
      m_last_a  = '0;
      m_last_cf = '0;
      obs_q.delete();
      bytes_q.delete();
      drive_frame(1, 4, 0, 0, 0);
      check_frame('{1, 4, 0, 0, 0, 16, 0, 25'h0000000, 0}, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
